// File: rtl/clk_duty_monitor.sv
// Duty-cycle monitor for a derived clock sampled in the clk_in domain.
// Define CLK_DUTY_MONITOR_SYNC_EN to insert a 2-flop synchronizer on sig_in.
module clk_duty_monitor #(
    parameter int CNT_W      = 8,
    parameter int EXP_HIGH   = 1,
    parameter int EXP_LOW    = 2,
    parameter int LOCK_COUNT = 4
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             enable,
    input  logic             sig_in,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] low_cnt,
    output logic             meas_valid,
    output logic             locked,
    output logic             err_pulse,
    output logic [7:0]       err_count
);

    localparam int LW = $clog2(LOCK_COUNT + 1);
    localparam logic [LW-1:0]    LOCK_MAX = LW'(LOCK_COUNT);
    localparam logic [CNT_W-1:0] EXP_H    = CNT_W'(EXP_HIGH);
    localparam logic [CNT_W-1:0] EXP_L    = CNT_W'(EXP_LOW);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_RISE,
        MEAS_HIGH,
        MEAS_LOW
    } state_t;

    state_t           state_q, state_d;
    logic             s, prev_q, rise, fall;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hi_cap_q, hi_cap_d;
    logic [LW-1:0]    lock_q, lock_d, lock_nx;
    logic [CNT_W-1:0] high_d, low_d;
    logic             mv_d, locked_d, err_d, err_evt;
    logic [7:0]       errc_d;

`ifdef CLK_DUTY_MONITOR_SYNC_EN
    logic [1:0] sync_q;
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) sync_q <= 2'b00;
        else     sync_q <= {sync_q[0], sig_in};
    end
    assign s = sync_q[1];
`else
    assign s = sig_in;
`endif

    assign rise = s & ~prev_q;
    assign fall = ~s & prev_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_cap_d = hi_cap_q;
        lock_d   = lock_q;
        high_d   = high_cnt;
        low_d    = low_cnt;
        mv_d     = 1'b0;
        locked_d = locked;
        err_d    = 1'b0;
        errc_d   = err_count;
        err_evt  = 1'b0;
        lock_nx  = (lock_q == LOCK_MAX) ? LOCK_MAX : lock_q + 1'b1;
        if (!enable) begin
            state_d  = IDLE;
            cnt_d    = '0;
            lock_d   = '0;
            locked_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: state_d = WAIT_RISE;
                WAIT_RISE: begin
                    if (rise) begin
                        state_d = MEAS_HIGH;
                        cnt_d   = CNT_ONE;
                    end
                end
                MEAS_HIGH: begin
                    if (fall) begin
                        hi_cap_d = cnt_q;
                        cnt_d    = CNT_ONE;
                        state_d  = MEAS_LOW;
                    end else if (cnt_q == CNT_MAX) begin
                        err_evt = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                MEAS_LOW: begin
                    if (rise) begin
                        high_d  = hi_cap_q;
                        low_d   = cnt_q;
                        mv_d    = 1'b1;
                        cnt_d   = CNT_ONE;
                        state_d = MEAS_HIGH;
                        if (hi_cap_q == EXP_H && cnt_q == EXP_L) begin
                            lock_d   = lock_nx;
                            locked_d = (lock_nx == LOCK_MAX);
                        end else begin
                            err_evt = 1'b1;
                        end
                    end else if (cnt_q == CNT_MAX) begin
                        err_evt = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            endcase
            if (err_evt) begin
                err_d    = 1'b1;
                errc_d   = (err_count == 8'hFF) ? err_count : err_count + 8'd1;
                lock_d   = '0;
                locked_d = 1'b0;
                // A phase that never ends restarts the search for a clean rise.
                if (!mv_d) begin
                    cnt_d   = '0;
                    state_d = WAIT_RISE;
                end
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            prev_q     <= 1'b0;
            cnt_q      <= '0;
            hi_cap_q   <= '0;
            lock_q     <= '0;
            high_cnt   <= '0;
            low_cnt    <= '0;
            meas_valid <= 1'b0;
            locked     <= 1'b0;
            err_pulse  <= 1'b0;
            err_count  <= '0;
        end else begin
            state_q    <= state_d;
            prev_q     <= s;
            cnt_q      <= cnt_d;
            hi_cap_q   <= hi_cap_d;
            lock_q     <= lock_d;
            high_cnt   <= high_d;
            low_cnt    <= low_d;
            meas_valid <= mv_d;
            locked     <= locked_d;
            err_pulse  <= err_d;
            err_count  <= errc_d;
        end
    end

endmodule

// File: tb/tb_clk_duty_monitor.sv
// Directed bench for clk_duty_monitor (default build, no synchronizer).
module tb_clk_duty_monitor;

    logic       clk_in, rst, enable, sig_in;
    logic [7:0] high_cnt, low_cnt, err_count;
    logic       meas_valid, locked, err_pulse;

    int total = 0;
    int bad   = 0;

    clk_duty_monitor dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .enable    (enable),
        .sig_in    (sig_in),
        .high_cnt  (high_cnt),
        .low_cnt   (low_cnt),
        .meas_valid(meas_valid),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    typedef struct {
        bit en;
        bit sig;
        bit mv;
        bit err;
        bit lk;
        int hi;
        int lo;
        int ec;
    } vec_t;

    vec_t vec[14];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cyc(input bit en, input bit sig);
        enable = en;
        sig_in = sig;
        @(negedge clk_in);
    endtask

    task automatic good_period();
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1);
    endtask

    task automatic chk_all(input string nm, input int hi, input int lo,
                           input int mv, input int lk, input int er,
                           input int ec);
        chk({nm, "_hi"}, int'(high_cnt), hi);
        chk({nm, "_lo"}, int'(low_cnt), lo);
        chk({nm, "_mv"}, int'(meas_valid), mv);
        chk({nm, "_lk"}, int'(locked), lk);
        chk({nm, "_err"}, int'(err_pulse), er);
        chk({nm, "_ec"}, int'(err_count), ec);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int nerr;
        int at;
        int nmv;
        rst = 1'b1;
        enable = 1'b0;
        sig_in = 1'b0;
        repeat (2) @(negedge clk_in);
        chk_all("reset", 0, 0, 0, 0, 0, 0);
        rst = 1'b0;

        vec[0]  = '{1, 0, 0, 0, 0, 0, 0, 0};
        vec[1]  = '{1, 1, 0, 0, 0, 0, 0, 0};
        vec[2]  = '{1, 0, 0, 0, 0, 0, 0, 0};
        vec[3]  = '{1, 0, 0, 0, 0, 0, 0, 0};
        vec[4]  = '{1, 1, 1, 0, 0, 1, 2, 0};
        vec[5]  = '{1, 0, 0, 0, 0, 1, 2, 0};
        vec[6]  = '{1, 0, 0, 0, 0, 1, 2, 0};
        vec[7]  = '{1, 1, 1, 0, 0, 1, 2, 0};
        vec[8]  = '{1, 0, 0, 0, 0, 1, 2, 0};
        vec[9]  = '{1, 0, 0, 0, 0, 1, 2, 0};
        vec[10] = '{1, 1, 1, 0, 0, 1, 2, 0};
        vec[11] = '{1, 0, 0, 0, 0, 1, 2, 0};
        vec[12] = '{1, 0, 0, 0, 0, 1, 2, 0};
        vec[13] = '{1, 1, 1, 0, 1, 1, 2, 0};
        for (int i = 0; i < 14; i++) begin
            cyc(vec[i].en, vec[i].sig);
            chk_all($sformatf("div3_%0d", i), vec[i].hi, vec[i].lo,
                    int'(vec[i].mv), int'(vec[i].lk), int'(vec[i].err),
                    vec[i].ec);
        end

        // one long-low period while locked
        cyc(1, 0); cyc(1, 0); cyc(1, 0); cyc(1, 1);
        chk_all("longlow", 1, 3, 1, 0, 1, 1);
        cyc(1, 0);
        chk("longlow_once", int'(err_pulse), 0);
        cyc(1, 0); cyc(1, 1);
        good_period(); good_period();
        chk("relock_3", int'(locked), 0);
        good_period();
        chk("relock_4", int'(locked), 1);
        chk("relock_ec", int'(err_count), 1);

        // 50% duty
        for (int i = 0; i < 3; i++) begin
            cyc(1, 1); cyc(1, 0); cyc(1, 0); cyc(1, 1);
            chk_all($sformatf("half_%0d", i), 2, 2, 1, 0, 1, 2 + i);
        end

        repeat (4) good_period();
        chk("relock2", int'(locked), 1);

        // enable drop while locked
        cyc(0, 0);
        chk_all("disable", 1, 2, 0, 0, 0, 4);
        cyc(1, 0);
        cyc(1, 1);
        chk("reen_rise1_mv", int'(meas_valid), 0);
        good_period();
        chk_all("reen_rise2", 1, 2, 1, 0, 0, 4);

        // stuck high
        nerr = 0;
        at = -1;
        nmv = 0;
        for (int i = 0; i < 300; i++) begin
            cyc(1, 1);
            if (err_pulse) begin
                nerr++;
                if (at < 0) at = i;
            end
            if (meas_valid) nmv++;
        end
        chk("stuck_nerr", nerr, 1);
        chk("stuck_at", at, 254);
        chk("stuck_mv", nmv, 0);
        chk("stuck_ec", int'(err_count), 5);
        cyc(1, 0); cyc(1, 1);
        chk("resume_rise1_mv", int'(meas_valid), 0);
        good_period();
        chk_all("resume", 1, 2, 1, 0, 0, 5);

        // reset mid-high while locked
        repeat (3) good_period();
        chk("prerst_lock", int'(locked), 1);
        #2 rst = 1'b1;
        #1 chk_all("rst_async", 0, 0, 0, 0, 0, 0);
        #14 rst = 1'b0;
        @(negedge clk_in);
        nmv = 0;
        cyc(1, 0);
        nmv += int'(meas_valid);
        cyc(1, 1);
        nmv += int'(meas_valid);
        cyc(1, 0);
        nmv += int'(meas_valid);
        cyc(1, 0);
        nmv += int'(meas_valid);
        chk("postrst_nomv", nmv, 0);
        cyc(1, 1);
        chk_all("postrst", 1, 2, 1, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clk_duty_monitor.md
Name: clk_duty_monitor

Overview:
- Receiving end of the divided-clock path: samples a derived clock (e.g. the divide-by-3, 33% duty output) in the clk_in domain.
- Measures the high and low phase lengths of every period in clk_in cycles and checks them against expected values.
- Reports lock status and error events so the divider's output is checked in-system as well as on the bench.

Parameters:
- CNT_W, 8, width of the phase counters and of high_cnt/low_cnt.
- EXP_HIGH, 1, expected high-phase length in clk_in cycles.
- EXP_LOW, 2, expected low-phase length in clk_in cycles.
- LOCK_COUNT, 4, consecutive matching periods required to assert locked.

Ports:
- clk_in  input  1  system clock; all logic on posedge.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  monitor enable; low forces IDLE.
- sig_in  input  1  derived clock under test, synchronous to clk_in.
- high_cnt  output  CNT_W  last measured high-phase length.
- low_cnt  output  CNT_W  last measured low-phase length.
- meas_valid  output  1  one-cycle pulse when high_cnt/low_cnt update.
- locked  output  1  LOCK_COUNT consecutive matching periods seen.
- err_pulse  output  1  one-cycle pulse on mismatch or timeout.
- err_count  output  8  saturating error counter.

Behaviour:
- Clock and reset: one clock, clk_in. Reset rst is asynchronous, active-high.
- Reset values: all outputs 0; state IDLE; prev, phase counter and lock counter 0.
- Edge detection on the sampled value s: prev <= s every cycle; rise = s & ~prev; fall = ~s & prev.
- FSM states: IDLE, WAIT_RISE, MEAS_HIGH, MEAS_LOW.
  - IDLE: enable=1 -> WAIT_RISE.
  - WAIT_RISE: rise -> MEAS_HIGH, cnt <= 1. No measurement is produced, because the preceding low phase is partial.
  - MEAS_HIGH: s=1 -> cnt+1. fall -> high_cnt <= cnt, cnt <= 1, MEAS_LOW.
  - MEAS_LOW: s=0 -> cnt+1. rise -> low_cnt <= cnt, meas_valid <= 1, cnt <= 1, MEAS_HIGH.
- Check, on the same edge as meas_valid, using the captured high value and current cnt:
  - Match (high==EXP_HIGH and low==EXP_LOW): lock counter +1, saturating at LOCK_COUNT. locked <= 1 when the new value equals LOCK_COUNT.
  - Mismatch: err_pulse <= 1, err_count +1 (saturating at 255), lock counter <= 0, locked <= 0.
- Timeout: cnt == 2^CNT_W-1 while still in the same phase raises err_pulse, err_count +1 (saturating), locked <= 0, lock counter <= 0, cnt <= 0, state -> WAIT_RISE. Covers stuck-high and stuck-low.
- Latency: high_cnt, low_cnt, meas_valid and err_pulse are registered and visible the cycle after the edge at which the terminating rise is sampled.
- enable=0: highest priority after rst. State -> IDLE, cnt and lock counter 0, locked 0, no pulses. high_cnt, low_cnt and err_count hold.
- Re-enable restarts from WAIT_RISE. The first measurement completes at the second rise.
- A reset mid-period discards the partial measurement.
- meas_valid and err_pulse are each never high for two consecutive cycles, except that err_pulse may repeat on consecutive periods.

Optional Feature:
- Macro: CLK_DUTY_MONITOR_SYNC_EN.
- Defined: sig_in passes through a 2-flop synchronizer before edge detection, so s = sync2. Adds exactly 2 cycles of latency to all outputs. Measured lengths are unchanged. Allows an asynchronous sig_in.
- Undefined: s = sig_in directly; sig_in must be synchronous to clk_in.

Test Plan:
- Divide-by-3 stimulus (1,0,0 repeating), enable=1, defaults -> every meas_valid shows high_cnt=1, low_cnt=2; locked rises with the 4th meas_valid; err_count stays 0.
- 50% stimulus (1,1,0,0 repeating) -> high_cnt=2, low_cnt=2, err_pulse with each meas_valid, err_count 1,2,3..., locked stays 0.
- Lock, then a single period of 1,0,0,0 -> low_cnt=3, err_pulse, locked drops; relocks after 4 further good periods.
- sig_in stuck high for 300 cycles -> err_pulse when cnt reaches 255, state WAIT_RISE; no further errors until toggling resumes.
- rst pulsed for 15 ns mid-high-phase while locked -> all outputs 0 immediately, no meas_valid for the partial period.
- enable dropped while locked -> locked=0 next cycle, high_cnt/low_cnt hold; re-enable gives the first meas_valid at the second rise.
